// File: rtl/mem_map_pkg.sv
// Shared types, constants and bus-steering helpers for the V810 memory-map controller.
package mem_map_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] ws;
    logic       dw16;
  } region_cfg_t;

  localparam logic [31:0] OPEN_BUS    = 32'hFFFF_FFFF;
  localparam int          TIMEOUT_CYC = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Selected halfword replicated onto both halves of the 32-bit bus.
  function automatic logic [31:0] half_dup(input logic [31:0] w, input logic hi);
    return hi ? {w[31:16], w[31:16]} : {w[15:0], w[15:0]};
  endfunction

  function automatic logic [3:0] nbe16(input logic [3:0] ben, input logic hi);
    return hi ? {ben[1:0], 2'b11} : {2'b11, ben[1:0]};
  endfunction

endpackage

// File: rtl/mem_map_decode.sv
// Combinational priority address decoder: lowest-indexed matching region wins.
module mem_map_decode
  import mem_map_pkg::*;
#(
  parameter int          NREG = 4,
  parameter logic [31:0] BASE [NREG] = '{32'h0000_0000, 32'hFFF0_0000, 32'h8000_0000, 32'h9000_0000},
  parameter logic [31:0] MASK [NREG] = '{32'h8000_0000, 32'hFFF0_0000, 32'hF000_0000, 32'hF000_0000}
) (
  input  logic [31:0]                  addr,
  output logic                         hit,
  output logic [idx_width(NREG)-1:0]   idx
);

  localparam int IW = idx_width(NREG);

  logic match_s;

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    match_s = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      match_s = ((addr & MASK[i]) == BASE[i]);
      idx     = match_s ? IW'(i) : idx;
      hit     = hit | match_s;
    end
  end

endmodule

// File: rtl/mem_map_ctlr.sv
// V810 external-bus slave: region decode, wait states, READYn/SZRQn and data steering.
// Optional macro MEM_MAP_TIMEOUT_EN: unmapped accesses time out and flag BERR.
module mem_map_ctlr
  import mem_map_pkg::*;
#(
  parameter int          NREG = 4,
  parameter int          AW   = 6,
  parameter logic [31:0] BASE [NREG] = '{32'h0000_0000, 32'hFFF0_0000, 32'h8000_0000, 32'h9000_0000},
  parameter logic [31:0] MASK [NREG] = '{32'h8000_0000, 32'hFFF0_0000, 32'hF000_0000, 32'hF000_0000}
) (
  input  logic                 CLK,
  input  logic                 RESn,
  input  logic                 CE,
  input  logic [31:0]          A,
  input  logic [3:0]           BEn,
  input  logic                 MRQn,
  input  logic                 RW,
  input  logic                 BCYSTn,
  input  logic [31:0]          D_O,
  output logic [31:0]          D_I,
  output logic                 READYn,
  output logic                 SZRQn,
  input  logic [4*NREG-1:0]    CFG_WS,
  input  logic [NREG-1:0]      CFG_DW16,
  output logic [NREG-1:0]      MEM_nCE,
  output logic                 MEM_nWE,
  output logic                 MEM_nOE,
  output logic [3:0]           MEM_nBE,
  output logic [AW-1:0]        MEM_A,
  output logic [31:0]          MEM_DI,
  input  logic [32*NREG-1:0]   MEM_DO,
  output logic                 BERR
);

  localparam int IW = idx_width(NREG);

`ifdef MEM_MAP_TIMEOUT_EN
  localparam logic       TIMEOUT_EN = 1'b1;
  localparam logic [4:0] MISS_CNT   = 5'(TIMEOUT_CYC);
`else
  localparam logic       TIMEOUT_EN = 1'b0;
  localparam logic [4:0] MISS_CNT   = 5'd0;
`endif

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            hit_q, hit_d, rw_q, rw_d, a1_q, a1_d, dw16_q, dw16_d;
  logic            pend_q, pend_d, prw_q, prw_d;
  logic [31:0]     pa_q, pa_d;
  logic [3:0]      pben_q, pben_d;
  logic            ready_n_q, ready_n_d, szrq_n_q, szrq_n_d, berr_q, berr_d;
  logic [31:0]     d_i_q, d_i_d, mem_di_q, mem_di_d;
  logic [NREG-1:0] mem_nce_q, mem_nce_d;
  logic            mem_nwe_q, mem_nwe_d, mem_noe_q, mem_noe_d;
  logic [3:0]      mem_nbe_q, mem_nbe_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;

  logic [31:0]     start_a_s, rd_s;
  logic [3:0]      start_ben_s;
  logic            start_rw_s, start_s, dec_hit_s;
  logic [IW-1:0]   dec_idx_s;
  region_cfg_t     start_cfg_s;
  logic [4:0]      start_cnt_s;

  // A cycle start captured during READY takes priority over live bus inputs.
  assign start_a_s        = pend_q ? pa_q : A;
  assign start_ben_s      = pend_q ? pben_q : BEn;
  assign start_rw_s       = pend_q ? prw_q : RW;
  assign start_s          = pend_q | (~BCYSTn & ~MRQn);
  assign start_cfg_s.ws   = CFG_WS[{dec_idx_s, 2'd0} +: 4];
  assign start_cfg_s.dw16 = CFG_DW16[dec_idx_s] & dec_hit_s;
  assign start_cnt_s      = dec_hit_s ? {1'b0, start_cfg_s.ws} : MISS_CNT;

  mem_map_decode #(.NREG(NREG), .BASE(BASE), .MASK(MASK)) u_decode (
    .addr (start_a_s),
    .hit  (dec_hit_s),
    .idx  (dec_idx_s)
  );

  // Next-state and registered-output computation; everything holds while CE is low.
  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;     idx_d = idx_q;   hit_d = hit_q;
    rw_d = rw_q;         a1_d = a1_q;       dw16_d = dw16_q;
    pend_d = pend_q;     pa_d = pa_q;       pben_d = pben_q; prw_d = prw_q;
    ready_n_d = ready_n_q; szrq_n_d = szrq_n_q; berr_d = berr_q; d_i_d = d_i_q;
    mem_nce_d = mem_nce_q; mem_nwe_d = mem_nwe_q; mem_noe_d = mem_noe_q;
    mem_nbe_d = mem_nbe_q; mem_a_d = mem_a_q; mem_di_d = mem_di_q;
    rd_s = 32'h0000_0000;
    if (CE) begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            pend_d    = 1'b0;
            hit_d     = dec_hit_s;
            idx_d     = dec_idx_s;
            rw_d      = start_rw_s;
            a1_d      = start_a_s[1];
            dw16_d    = start_cfg_s.dw16;
            cnt_d     = start_cnt_s;
            state_d   = (start_cnt_s == 5'd0) ? READY : WAIT;
            mem_a_d   = start_a_s[AW+1:2];
            mem_nce_d = dec_hit_s ? ~(NREG'(1'b1) << dec_idx_s) : '1;
            mem_noe_d = ~(dec_hit_s & start_rw_s);
            mem_nwe_d = ~(dec_hit_s & ~start_rw_s);
            mem_nbe_d = start_cfg_s.dw16 ? nbe16(start_ben_s, start_a_s[1]) : start_ben_s;
            mem_di_d  = start_cfg_s.dw16 ? half_dup(D_O, 1'b0) : D_O;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          cnt_d    = cnt_q - 5'd1;
          mem_di_d = dw16_q ? half_dup(D_O, 1'b0) : D_O;
          state_d  = (cnt_q == 5'd1) ? READY : WAIT;
        end
        READY: begin
          state_d   = IDLE;
          mem_nce_d = '1;
          mem_noe_d = 1'b1;
          mem_nwe_d = 1'b1;
          mem_nbe_d = 4'hF;
          if (~BCYSTn & ~MRQn) begin
            pend_d = 1'b1;
            pa_d   = A;
            pben_d = BEn;
            prw_d  = RW;
          end else begin
            pend_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      endcase
      if (state_d == READY) begin
        rd_s      = MEM_DO[{idx_d, 5'd0} +: 32];
        ready_n_d = 1'b0;
        szrq_n_d  = ~dw16_d;
        berr_d    = ~hit_d & TIMEOUT_EN;
        if (!hit_d) begin
          d_i_d = OPEN_BUS;
        end else if (rw_d) begin
          d_i_d = dw16_d ? half_dup(rd_s, a1_d) : rd_s;
        end else begin
          d_i_d = d_i_q;
        end
      end else begin
        ready_n_d = 1'b1;
        szrq_n_d  = 1'b1;
        berr_d    = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset abandons any cycle in flight.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q <= IDLE;   cnt_q <= 5'd0;   idx_q <= '0;    hit_q <= 1'b0;
      rw_q <= 1'b0;      a1_q <= 1'b0;    dw16_q <= 1'b0;
      pend_q <= 1'b0;    pa_q <= 32'h0;   pben_q <= 4'hF; prw_q <= 1'b0;
      ready_n_q <= 1'b1; szrq_n_q <= 1'b1; berr_q <= 1'b0; d_i_q <= 32'h0;
      mem_nce_q <= '1;   mem_nwe_q <= 1'b1; mem_noe_q <= 1'b1;
      mem_nbe_q <= 4'hF; mem_a_q <= '0;   mem_di_q <= 32'h0;
    end else begin
      state_q <= state_d;     cnt_q <= cnt_d;     idx_q <= idx_d;   hit_q <= hit_d;
      rw_q <= rw_d;           a1_q <= a1_d;       dw16_q <= dw16_d;
      pend_q <= pend_d;       pa_q <= pa_d;       pben_q <= pben_d; prw_q <= prw_d;
      ready_n_q <= ready_n_d; szrq_n_q <= szrq_n_d; berr_q <= berr_d; d_i_q <= d_i_d;
      mem_nce_q <= mem_nce_d; mem_nwe_q <= mem_nwe_d; mem_noe_q <= mem_noe_d;
      mem_nbe_q <= mem_nbe_d; mem_a_q <= mem_a_d; mem_di_q <= mem_di_d;
    end
  end

  assign D_I     = d_i_q;
  assign READYn  = ready_n_q;
  assign SZRQn   = szrq_n_q;
  assign BERR    = berr_q;
  assign MEM_nCE = mem_nce_q;
  assign MEM_nWE = mem_nwe_q;
  assign MEM_nOE = mem_noe_q;
  assign MEM_nBE = mem_nbe_q;
  assign MEM_A   = mem_a_q;
  assign MEM_DI  = mem_di_q;

endmodule

// File: tb/tb_mem_map_ctlr.sv
// Directed self-checking bench for mem_map_ctlr (honours MEM_MAP_TIMEOUT_EN if defined).
module tb_mem_map_ctlr;

  localparam logic [31:0] TB_BASE [4] = '{32'h0000_0000, 32'hFFF0_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [31:0] TB_MASK [4] = '{32'hF000_0000, 32'hFFF0_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [31:0] R0 = 32'hA0A0_0001, R1 = 32'hB1B1_0002, R2 = 32'h1234_5678, R3 = 32'hC3C3_0004;
`ifdef MEM_MAP_TIMEOUT_EN
  localparam int   EXP_MISS_LAT = 17;
  localparam logic EXP_BERR     = 1'b1;
`else
  localparam int   EXP_MISS_LAT = 1;
  localparam logic EXP_BERR     = 1'b0;
`endif

  logic        CLK = 1'b0, RESn = 1'b0, CE = 1'b1;
  logic [31:0] A = 32'h0, D_O = 32'h0, D_I, MEM_DI;
  logic [3:0]  BEn = 4'hF, MEM_nBE, MEM_nCE, CFG_DW16 = 4'b0100;
  logic        MRQn = 1'b1, RW = 1'b1, BCYSTn = 1'b1, READYn, SZRQn, MEM_nWE, MEM_nOE, BERR;
  logic [15:0] CFG_WS = {4'd7, 4'd1, 4'd0, 4'd3};
  logic [5:0]  MEM_A;
  logic [127:0] MEM_DO = {R3, R2, R1, R0};

  int n_checks = 0, n_pass = 0;
  int lat, nce_low, nwe_low;

  mem_map_ctlr #(.NREG(4), .AW(6), .BASE(TB_BASE), .MASK(TB_MASK)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .A(A), .BEn(BEn), .MRQn(MRQn), .RW(RW),
    .BCYSTn(BCYSTn), .D_O(D_O), .D_I(D_I), .READYn(READYn), .SZRQn(SZRQn),
    .CFG_WS(CFG_WS), .CFG_DW16(CFG_DW16), .MEM_nCE(MEM_nCE), .MEM_nWE(MEM_nWE),
    .MEM_nOE(MEM_nOE), .MEM_nBE(MEM_nBE), .MEM_A(MEM_A), .MEM_DI(MEM_DI),
    .MEM_DO(MEM_DO), .BERR(BERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one access and return once READYn is seen low (bounded), counting strobe cycles.
  task automatic run_cycle(input logic [31:0] a, input logic rw, input logic [31:0] dout,
                           input logic [3:0] ben, input logic poke_cfg,
                           output int l, output int nce_n, output int nwe_n);
    A = a; RW = rw; D_O = dout; BEn = ben; MRQn = 1'b0; BCYSTn = 1'b0;
    tick();
    BCYSTn = 1'b1;
    if (poke_cfg) CFG_WS[3:0] = 4'd0;
    l = 1; nce_n = 0; nwe_n = 0;
    if (MEM_nCE != 4'hF) nce_n++;
    if (!MEM_nWE) nwe_n++;
    while (READYn !== 1'b0 && l < 40) begin
      tick();
      l++;
      if (MEM_nCE != 4'hF) nce_n++;
      if (!MEM_nWE) nwe_n++;
    end
  endtask

  initial begin
    #12;
    check("rst_readyn", READYn, 1'b1);
    check("rst_szrqn", SZRQn, 1'b1);
    check("rst_di", D_I, 32'h0);
    check("rst_nce", MEM_nCE, 4'hF);
    check("rst_nwe_noe", {MEM_nWE, MEM_nOE}, 2'b11);
    check("rst_nbe", MEM_nBE, 4'hF);
    check("rst_berr", BERR, 1'b0);
    RESn = 1'b1;
    tick();

    run_cycle(32'hFFF0_0004, 1'b1, 32'h0, 4'h0, 1'b0, lat, nce_low, nwe_low);
    check("rom_lat", lat, 1);
    check("rom_di", D_I, R1);
    check("rom_nce", MEM_nCE, 4'b1101);
    check("rom_noe", MEM_nOE, 1'b0);
    check("rom_mema", MEM_A, 6'd1);
    check("rom_szrqn", SZRQn, 1'b1);
    tick();
    check("rom_ready_one_cycle", READYn, 1'b1);

    run_cycle(32'h0000_0008, 1'b0, 32'hDEAD_BEEF, 4'h0, 1'b0, lat, nce_low, nwe_low);
    check("wr_lat", lat, 4);
    check("wr_nce_cycles", nce_low, 4);
    check("wr_nwe_cycles", nwe_low, 4);
    check("wr_nce", MEM_nCE, 4'b1110);
    check("wr_memdi", MEM_DI, 32'hDEAD_BEEF);
    check("wr_mema", MEM_A, 6'd2);
    check("wr_nbe", MEM_nBE, 4'h0);
    tick();
    check("wr_release", {READYn, MEM_nWE, MEM_nCE}, 6'b111111);

    run_cycle(32'h1000_0002, 1'b1, 32'h0, 4'h0, 1'b0, lat, nce_low, nwe_low);
    check("h16_lat", lat, 2);
    check("h16_di", D_I, 32'h1234_1234);
    check("h16_szrqn", SZRQn, 1'b0);
    tick();
    check("h16_szrqn_release", SZRQn, 1'b1);

    run_cycle(32'h1000_0002, 1'b0, 32'h0000_CAFE, 4'b1100, 1'b0, lat, nce_low, nwe_low);
    check("w16_memdi", MEM_DI, 32'hCAFE_CAFE);
    check("w16_nbe", MEM_nBE, 4'b0011);
    tick();

    // Mid-cycle CFG change must not alter the latched wait count.
    run_cycle(32'h0000_0020, 1'b1, 32'h0, 4'h0, 1'b1, lat, nce_low, nwe_low);
    check("cfg_sampled_lat", lat, 4);
    check("cfg_sampled_di", D_I, R0);
    tick();

    // Back-to-back: second BCYSTn arrives during the first READY cycle.
    A = 32'h0000_0010; RW = 1'b1; MRQn = 1'b0; BCYSTn = 1'b0;
    tick();
    check("b2b_first_ready", READYn, 1'b0);
    check("b2b_first_di", D_I, R0);
    A = 32'hFFF0_0008;
    tick();
    BCYSTn = 1'b1;
    check("b2b_gap", READYn, 1'b1);
    tick();
    check("b2b_second_ready", READYn, 1'b0);
    check("b2b_second_di", D_I, R1);
    check("b2b_second_mema", MEM_A, 6'd2);
    tick();

    run_cycle(32'h4000_0000, 1'b1, 32'h0, 4'h0, 1'b0, lat, nce_low, nwe_low);
    check("miss_lat", lat, EXP_MISS_LAT);
    check("miss_di", D_I, 32'hFFFF_FFFF);
    check("miss_nce_cycles", nce_low, 0);
    check("miss_berr", BERR, EXP_BERR);
    tick();
    check("miss_berr_release", BERR, 1'b0);

    run_cycle(32'hFFF0_0004, 1'b1, 32'h0, 4'h0, 1'b0, lat, nce_low, nwe_low);
    CE = 1'b0;
    tick();
    check("ce_hold_readyn", READYn, 1'b0);
    check("ce_hold_nce", MEM_nCE, 4'b1101);
    CE = 1'b1;
    tick();
    check("ce_resume", READYn, 1'b1);

    A = 32'h2000_0000; RW = 1'b1; MRQn = 1'b0; BCYSTn = 1'b0;
    tick();
    BCYSTn = 1'b1;
    tick();
    check("rst_mid_wait_active", MEM_nCE, 4'b0111);
    RESn = 1'b0;
    #1;
    check("rst_mid_nce", MEM_nCE, 4'hF);
    check("rst_mid_noe", MEM_nOE, 1'b1);
    check("rst_mid_readyn", READYn, 1'b1);
    check("rst_mid_di", D_I, 32'h0);
    tick();
    RESn = 1'b1;
    tick();
    run_cycle(32'hFFF0_0004, 1'b1, 32'h0, 4'h0, 1'b0, lat, nce_low, nwe_low);
    check("post_rst_lat", lat, 1);
    check("post_rst_di", D_I, R1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
